signed_sub_with_saturation_pipe: RTL and testbench

//   Streaming signed subtractor with saturation: diff = sat(a - b), two's complement, W bits.

---
 rtl/sat_arith_pkg.sv | 20 ++
 rtl/signed_sub_with_saturation_pipe_if.sv | 26 ++
 rtl/valid_ready_reg.sv | 34 +++
 rtl/signed_sub_with_saturation_pipe.sv | 100 ++++++++++
 tb/tb_signed_sub_with_saturation_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sat_arith_pkg.sv
// rtl/sat_arith_pkg.sv - saturation limits and result classification shared by saturating arithmetic blocks
package sat_arith_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_kind_t;

    // Largest positive value of a w-bit two's complement number.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative value of a w-bit two's complement number.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/signed_sub_with_saturation_pipe_if.sv
// rtl/signed_sub_with_saturation_pipe_if.sv - operand/result valid-ready streams of the saturating subtractor
interface signed_sub_with_saturation_pipe_if #(
    parameter int W = 4
);
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         down_valid;
    logic         down_ready;
    logic [W-1:0] diff;
    logic         sat_pos;
    logic         sat_neg;

    // Producer of operands and consumer of results.
    modport master (
        output up_valid, a, b, down_ready,
        input  up_ready, down_valid, diff, sat_pos, sat_neg
    );

    // The subtractor itself.
    modport slave (
        input  up_valid, a, b, down_ready,
        output up_ready, down_valid, diff, sat_pos, sat_neg
    );
endinterface

// File: rtl/valid_ready_reg.sv
// rtl/valid_ready_reg.sv - single valid/ready pipeline register slice without skid buffer
module valid_ready_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);
    logic          r_valid;
    logic [DW-1:0] r_data;

    // The slice can take new data when empty or when its content leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load on upstream transfer; hold payload stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// rtl/signed_sub_with_saturation_pipe.sv - two-stage streaming signed subtractor with saturation and event counter
module signed_sub_with_saturation_pipe
    import sat_arith_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    signed_sub_with_saturation_pipe_if.slave s_if,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      sat_cnt
);
    localparam logic [W-1:0]     MAX_V   = W'(sat_max(W));
    localparam logic [W-1:0]     MIN_V   = W'(sat_min(W));
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [W-1:0]     w_raw;
    logic [W+1:0]     w_s1_in;
    logic             w_s1_valid;
    logic [W+1:0]     w_s1_data;
    logic             w_s2_ready;
    logic [W-1:0]     w_s1_raw;
    logic             w_s1_a_sign;
    logic             w_s1_b_sign;
    logic             w_overflow;
    logic [W-1:0]     w_diff;
    sat_kind_t        w_kind;
    logic [W+1:0]     w_s2_in;
    logic [W+1:0]     w_s2_data;
    sat_kind_t        w_s2_kind;
    logic [CNT_W-1:0] r_sat_cnt;

    // Stage 1 keeps the wrapped difference and both operand signs for the overflow test.
    assign w_raw   = s_if.a - s_if.b;
    assign w_s1_in = {w_raw, s_if.a[W-1], s_if.b[W-1]};

    valid_ready_reg #(.DW(W + 2)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (s_if.up_valid),
        .o_ready (s_if.up_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data)
    );

    assign w_s1_raw    = w_s1_data[W+1:2];
    assign w_s1_a_sign = w_s1_data[1];
    assign w_s1_b_sign = w_s1_data[0];

    // Subtraction overflows only for operands of opposite sign whose wrapped result
    // changed sign away from the minuend; clamp toward the minuend's sign.
    always_comb begin
        w_overflow = (w_s1_a_sign != w_s1_b_sign) && (w_s1_raw[W-1] != w_s1_a_sign);
        w_diff     = w_s1_raw;
        w_kind     = SAT_NONE;
        if (w_overflow) begin
            if (!w_s1_a_sign) begin
                w_diff = MAX_V;
                w_kind = SAT_POS;
            end else begin
                w_diff = MIN_V;
                w_kind = SAT_NEG;
            end
        end
    end

    assign w_s2_in = {w_diff, w_kind};

    valid_ready_reg #(.DW(W + 2)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (s_if.down_valid),
        .i_ready (s_if.down_ready),
        .o_data  (w_s2_data)
    );

    assign s_if.diff    = w_s2_data[W+1:2];
    assign w_s2_kind    = sat_kind_t'(w_s2_data[1:0]);
    assign s_if.sat_pos = (w_s2_kind == SAT_POS);
    assign s_if.sat_neg = (w_s2_kind == SAT_NEG);
    assign sat_cnt      = r_sat_cnt;

    // Count delivered saturated results; clear wins, and the count sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (cnt_clr) begin
            r_sat_cnt <= '0;
        end else if (s_if.down_valid && s_if.down_ready && (w_s2_kind != SAT_NONE)
                     && (r_sat_cnt != CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// tb/tb_signed_sub_with_saturation_pipe.sv - scoreboard bench for the saturating subtractor pipeline
module tb_signed_sub_with_saturation_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [7:0] sat_cnt;

    always #5 clk = ~clk;

    signed_sub_with_saturation_pipe_if #(.W(4)) u_if ();

    signed_sub_with_saturation_pipe #(.W(4), .CNT_W(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_if    (u_if),
        .cnt_clr (cnt_clr),
        .sat_cnt (sat_cnt)
    );

    typedef struct packed {
        logic [3:0] d;
        logic       p;
        logic       n;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         accepted = 0;
    bit         rdone = 0;
    bit         prev_stall = 0;
    logic [3:0] prev_diff = '0;
    logic       prev_pos = 1'b0;
    logic       prev_neg = 1'b0;
    int         va, vb, ra, rb, rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every down transfer, and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && u_if.down_valid) begin
                chk("stall_diff", int'(u_if.diff), int'(prev_diff));
                chk("stall_pos", int'(u_if.sat_pos), int'(prev_pos));
                chk("stall_neg", int'(u_if.sat_neg), int'(prev_neg));
            end
            if (u_if.down_valid && u_if.down_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("diff", int'(u_if.diff), int'(mon_e.d));
                    chk("sat_pos", int'(u_if.sat_pos), int'(mon_e.p));
                    chk("sat_neg", int'(u_if.sat_neg), int'(mon_e.n));
                end
            end
            prev_stall = u_if.down_valid && !u_if.down_ready;
            prev_diff  = u_if.diff;
            prev_pos   = u_if.sat_pos;
            prev_neg   = u_if.sat_neg;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair; the expected result enters the scoreboard on acceptance.
    task automatic send(input int a, input int b, input int ed, input int ep, input int en);
        exp_t e;
        bit   ok;
        ok = 0;
        u_if.up_valid = 1'b1;
        u_if.a = 4'(a);
        u_if.b = 4'(b);
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (u_if.up_ready) begin
                ok = 1;
                e.d = 4'(ed);
                e.p = ep[0];
                e.n = en[0];
                q.push_back(e);
                accepted++;
                last_acc_cyc = cyc;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        u_if.up_valid = 1'b0;
    endtask

    task automatic wait_dv();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (u_if.down_valid) seen = 1;
        end
        if (seen) chk("latency", cyc - last_acc_cyc, 2);
        else chk("dv_timeout", 0, 1);
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !u_if.down_valid) break;
        end
        chk("drain_queue", q.size(), 0);
        step();
    endtask

    function automatic int ref_sub(input int a, input int b);
        int d;
        d = a - b;
        if (d > 7) return 7;
        if (d < -8) return -8;
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u_if.up_valid   = 1'b0;
        u_if.a          = '0;
        u_if.b          = '0;
        u_if.down_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_up_ready", int'(u_if.up_ready), 1);
        chk("rst_down_valid", int'(u_if.down_valid), 0);
        chk("rst_diff", int'(u_if.diff), 0);
        chk("rst_flags", int'({u_if.sat_pos, u_if.sat_neg}), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        rst_n = 1'b1;
        step();

        // Plain differences with latency measurement.
        send(3, 5, -2, 0, 0);
        wait_dv();
        send(-2, -7, 5, 0, 0);
        wait_dv();

        // Saturation boundaries, back to back.
        send(7, -1, 7, 1, 0);
        send(-8, 1, -8, 0, 1);
        send(-1, -8, 7, 0, 0);
        drain();

        // Backpressure: stall four cycles while six operands are offered.
        u_if.down_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(1, 2, -1, 0, 0);
                send(4, 1, 3, 0, 0);
                send(-3, 2, -5, 0, 0);
                send(5, 5, 0, 0, 0);
                send(-4, -6, 2, 0, 0);
                send(6, -2, 7, 1, 0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_accepted", accepted, 2);
                chk("stall_up_ready", int'(u_if.up_ready), 0);
                chk("stall_down_valid", int'(u_if.down_valid), 1);
                chk("stall_head_diff", int'(u_if.diff), 15);
                step();
                u_if.down_ready = 1'b1;
            end
        join
        drain();
        chk("stall_total_accepted", accepted, 6);

        // Counter saturation at 255 (three earlier saturations plus 300 more).
        for (int i = 0; i < 300; i++) send(0, -8, 7, 1, 0);
        drain();
        chk("sat_cnt_max", int'(sat_cnt), 255);

        // Clear coincident with a saturated transfer.
        fork
            send(0, -8, 7, 1, 0);
            begin
                for (int i = 0; i < 20 && !u_if.down_valid; i++) @(negedge clk);
                cnt_clr = 1'b1;
                @(posedge clk);
                #1;
                cnt_clr = 1'b0;
            end
        join
        drain();
        chk("sat_cnt_clr_priority", int'(sat_cnt), 0);
        send(-8, 1, -8, 0, 1);
        drain();
        chk("sat_cnt_after_clr", int'(sat_cnt), 1);

        // Asynchronous reset with a full, stalled pipe.
        u_if.down_ready = 1'b0;
        send(0, -8, 7, 1, 0);
        send(-8, 1, -8, 0, 1);
        chk("full_down_valid", int'(u_if.down_valid), 1);
        chk("full_up_ready", int'(u_if.up_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_down_valid", int'(u_if.down_valid), 0);
        chk("async_sat_cnt", int'(sat_cnt), 0);
        chk("async_up_ready", int'(u_if.up_ready), 1);
        q.delete();
        step();
        rst_n = 1'b1;
        u_if.down_ready = 1'b1;
        step();
        send(2, 3, -1, 0, 0);
        wait_dv();
        drain();

        // Random operands with random valid gaps and random backpressure.
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    va = int'($urandom_range(0, 15));
                    vb = int'($urandom_range(0, 15));
                    ra = (va > 7) ? va - 16 : va;
                    rb = (vb > 7) ? vb - 16 : vb;
                    rd = ref_sub(ra, rb);
                    send(ra, rb, rd, (ra - rb > 7) ? 1 : 0, (ra - rb < -8) ? 1 : 0);
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    step();
                    u_if.down_ready = ($urandom_range(0, 3) != 0);
                end
                u_if.down_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
